inst_buffer: RTL and testbench

//  Decoupling FIFO between inst_fetch (producer of pipe_if_t {vaddr, inst} via hand_shake_ifid)
//  and the decode stage. Absorbs decode stalls without throttling icache reads and discards
//  all buffered instructions on branch resolution or exception.
//  A registered queue: an accepted instruction is visible at the output no earlier than the next cycle.

---
 rtl/inst_buffer.sv | 81 ++++++++
 tb/tb_inst_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Registered FIFO between instruction fetch and decode. It absorbs decode stalls and
// drops all buffered instructions on flush. Reset also clears the storage.
module inst_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_vaddr,
    input  logic [DATA_WIDTH-1:0]      in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_vaddr,
    output logic [DATA_WIDTH-1:0]      out_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] vaddr_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem_r  [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;

    // Full/empty come straight from the occupancy register, so ready never
    // depends on out_ready and a full buffer cannot pass a beat through.
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign push_s    = in_valid & ~full_s;
    assign pop_s     = out_ready & ~empty_s;

    assign in_ready  = ~full_s;
    assign out_valid = ~empty_s;
    assign count     = count_r;
    assign out_vaddr = vaddr_mem_r[rd_ptr_r];
    assign out_inst  = inst_mem_r[rd_ptr_r];

    // Pointer and occupancy update; reset and flush discard any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; only reset clears it, a flush leaves stale data behind the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vaddr_mem_r[i] <= '0;
                inst_mem_r[i]  <= '0;
            end
        end else if (push_s && !flush) begin
            vaddr_mem_r[wr_ptr_r] <= in_vaddr;
            inst_mem_r[wr_ptr_r]  <= in_inst;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: the driver queues every accepted beat and a
// monitor pops and compares each beat the buffer hands to decode.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_vaddr = 32'h0;
    logic [31:0] in_inst = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_vaddr;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb [$];

    inst_buffer #(.DEPTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_vaddr(out_vaddr), .out_inst(out_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One clock cycle: inputs applied at the falling edge, model updated, count checked next low phase.
    task automatic cycle(input logic v, input logic [31:0] va, input logic [31:0] ins,
                         input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_vaddr  = va;
        in_inst   = ins;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        if (r || fl) sb.delete();
        else if (v && in_ready) sb.push_back({va, ins});
        @(posedge clk);
        @(negedge clk);
        check("count_vs_model", 32'(count), 32'(sb.size()));
    endtask

    task automatic drain();
        int n = 0;
        while (out_valid && n < 20) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("drain_empty", 32'(out_valid), 32'h0);
    endtask

    // Monitor: compare every beat decode actually consumes against the scoreboard head.
    always begin
        @(negedge clk);
        #3;
        if (!rst && !flush && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pop_underflow: got %h/%h expected no output", out_vaddr, out_inst);
            end else begin
                logic [63:0] exp_v;
                exp_v = sb.pop_front();
                if ({out_vaddr, out_inst} !== exp_v) begin
                    n_err++;
                    $display("FAIL pop_data: got %h/%h expected %h/%h",
                             out_vaddr, out_inst, exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        @(negedge clk);
        // 1: reset
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        check("rst_count", 32'(count), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_vaddr", out_vaddr, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);

        // 2: streaming with decode always ready
        check("stream_pre_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'hbfc00000 + 32'(i * 4), 32'(i + 1), 1'b1, 1'b0, 1'b0);
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_count", 32'(count), 32'h1);
        end
        drain();

        // 3: fill while stalled, then one pop with fetch still offering
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'hbfc00000 + 32'(i * 4), 32'h11 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        check("full_count", 32'(count), 32'h4);
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_head_vaddr", out_vaddr, 32'hbfc00000);
        check("full_head_inst", out_inst, 32'h11);
        cycle(1'b1, 32'hbfc00010, 32'h15, 1'b1, 1'b0, 1'b0);
        check("pop_on_full_count", 32'(count), 32'h3);
        check("pop_on_full_ready", 32'(in_ready), 32'h1);
        check("pop_on_full_head", out_vaddr, 32'hbfc00004);
        cycle(1'b1, 32'hbfc00010, 32'h15, 1'b0, 1'b0, 1'b0);
        drain();

        // 4: wrap with decode ready every other cycle
        j = 0;
        for (int i = 0; i < 10; i++) begin
            logic acc;
            acc = in_ready;
            cycle(1'b1, 32'hbfc00200 + 32'(j * 4), 32'ha0 + 32'(j), 1'(i % 2), 1'b0, 1'b0);
            if (acc) j++;
            check("wrap_count_le4", 32'(count <= 3'd4), 32'h1);
        end
        drain();

        // 5: flush with push and pop requested in the same cycle
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hbfc00300 + 32'(i * 4), 32'hc0 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        check("preflush_count", 32'(count), 32'h3);
        cycle(1'b1, 32'hbfc00400, 32'hdead, 1'b1, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'h0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        cycle(1'b1, 32'hbfc00100, 32'h00000042, 1'b0, 1'b0, 1'b0);
        check("post_flush_vaddr", out_vaddr, 32'hbfc00100);
        check("post_flush_inst", out_inst, 32'h00000042);
        check("post_flush_count", 32'(count), 32'h1);
        drain();

        // 6: reset mid-operation with a push active
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 32'hbfc00500 + 32'(i * 4), 32'he0 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        check("prerst_count", 32'(count), 32'h2);
        cycle(1'b1, 32'hbfc00600, 32'hbeef, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        in_valid = 1'b0;
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_vaddr", out_vaddr, 32'h0);
        check("midrst_out_inst", out_inst, 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
